fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one instruction-memory request at a time,
// hands the returned word downstream, follows redirects and traps on
// misaligned targets or a memory that never answers.
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        CLK,
  input  logic        ResetN,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] RetiredCount,
  output logic        FetchTimeout,
  output logic        Misaligned
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    DROP  = 3'd3,
    ERROR = 3'd4
  } state_t;

  // The wait counter is 4 bits wide, so MAX_WAIT is expected in 1..15.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] instr_nxt, pc_nxt, retired_nxt;
  logic        timeout_nxt, misaligned_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        redirect_bad;

  assign redirect_bad = Redirect && (RedirectTarget[1:0] != 2'b00);

  // All outputs come straight from registered state.
  assign ImemReq    = (state == FETCH);
  assign ImemAddr   = fetch_pc;
  assign InstrValid = (state == ISSUE);

  // Next-state and next-register-value decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    instr_nxt      = Instr;
    pc_nxt         = PC;
    retired_nxt    = RetiredCount;
    timeout_nxt    = FetchTimeout;
    misaligned_nxt = Misaligned;
    wait_cnt_nxt   = wait_cnt;

    unique case (state)
      IDLE: begin
        state_nxt    = FETCH;
        fetch_pc_nxt = RESET_VECTOR;
        wait_cnt_nxt = 4'd0;
      end

      FETCH: begin
        if (redirect_bad) begin
          misaligned_nxt = 1'b1;
          state_nxt      = ERROR;
        end else if (Redirect) begin
          // A response arriving alongside the redirect is simply dropped;
          // otherwise it is still in flight and must be drained in DROP.
          fetch_pc_nxt = RedirectTarget;
          wait_cnt_nxt = 4'd0;
          state_nxt    = ImemReady ? FETCH : DROP;
        end else if (ImemReady) begin
          instr_nxt = ImemData;
          pc_nxt    = fetch_pc;
          state_nxt = ISSUE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end

      ISSUE: begin
        if (redirect_bad) begin
          misaligned_nxt = 1'b1;
          state_nxt      = ERROR;
        end else if (Redirect) begin
          fetch_pc_nxt = RedirectTarget;
          wait_cnt_nxt = 4'd0;
          state_nxt    = FETCH;
        end else if (!Stall) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          retired_nxt  = RetiredCount + 32'd1;
          wait_cnt_nxt = 4'd0;
          state_nxt    = FETCH;
        end
      end

      DROP: begin
        if (redirect_bad) begin
          misaligned_nxt = 1'b1;
          state_nxt      = ERROR;
        end else begin
          // A redirect here only retargets; the stale response is still owed.
          if (Redirect) fetch_pc_nxt = RedirectTarget;
          if (ImemReady) begin
            wait_cnt_nxt = 4'd0;
            state_nxt    = FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end
      end

      ERROR: begin
        state_nxt = ERROR;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      fetch_pc     <= RESET_VECTOR;
      Instr        <= 32'd0;
      PC           <= 32'd0;
      RetiredCount <= 32'd0;
      FetchTimeout <= 1'b0;
      Misaligned   <= 1'b0;
      wait_cnt     <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      Instr        <= instr_nxt;
      PC           <= pc_nxt;
      RetiredCount <= retired_nxt;
      FetchTimeout <= timeout_nxt;
      Misaligned   <= misaligned_nxt;
      wait_cnt     <= wait_cnt_nxt;
    end
  end

endmodule
